// File: rtl/crtc_text_pixel_gen_if.sv
// VRAM read port between the text pixel generator (master) and the VRAM arbiter (slave).
// Latency: none, signal bundle only.
// Backpressure: the master holds vram_req and vram_addr until the slave returns vram_ack.
//
// Signals:
//   vram_req   master -> slave  read request, held until acknowledged
//   vram_addr  master -> slave  byte address, stable while vram_req=1
//   vram_ack   slave -> master  vram_data valid this cycle; ends the current request
//   vram_data  slave -> master  read data byte
interface crtc_text_pixel_gen_if #(
    parameter int VRAM_AW = 15
) ();
    logic               vram_req;
    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_ack;
    logic [7:0]         vram_data;

    modport master (output vram_req, output vram_addr, input vram_ack, input vram_data);
    modport slave  (input vram_req, input vram_addr, output vram_ack, output vram_data);
endinterface

// File: rtl/crtc_text_pixel_gen.sv
// CGA-style text pixel generator: fetches char/attr/font for each cell and serialises 8 IRGB pixels.
// Latency: a cell latched at char_ce N is displayed from char_ce N+1; sync and blank are delayed to match.
// Backpressure: a fetch that misses its cell slot is dropped, the cell is shown black and underrun pulses.
//
// Ports: clk/reset_n (synchronous, active low); pix_ce/char_ce dot and cell strobes;
// mem_addr/row_addr/display_enable/cursor/hsync_in/vsync_in from the CRTC; blink_mode;
// vram (master side of crtc_text_pixel_gen_if); font_addr/font_data to a 1-clk font ROM;
// video (IRGB), hsync_o, vsync_o, blank_o, underrun.
// Optional macro FONT_8X16_EN: 12-bit font_addr {char, row_addr[3:0]} instead of 11-bit {char, row_addr[2:0]}.
module crtc_text_pixel_gen #(
    parameter int VRAM_AW   = 15,
    parameter int BLINK_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_ce,
    input  logic                  char_ce,
    input  logic [13:0]           mem_addr,
    input  logic [4:0]            row_addr,
    input  logic                  display_enable,
    input  logic                  cursor,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  blink_mode,
    crtc_text_pixel_gen_if.master vram,
`ifdef FONT_8X16_EN
    output logic [11:0]           font_addr,
`else
    output logic [10:0]           font_addr,
`endif
    input  logic [7:0]            font_data,
    output logic [3:0]            video,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  blank_o,
    output logic                  underrun
);
`ifdef FONT_8X16_EN
    localparam int ROW_W = 4;
`else
    localparam int ROW_W = 3;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CHAR, S_ATTR, S_FONT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               cce, ack_ok, fetch_ok, miss;
    logic               req_r, req_gap;
    logic [VRAM_AW-1:0] vram_addr_r;

    // stage A: context of the cell being fetched
    logic [13:0]        a_addr;
    logic [ROW_W-1:0]   a_row;
    logic               a_de, a_cur, a_hs, a_vs;
    logic [7:0]         attr_r, pend_pat, pend_attr;

    // stage B: cell being displayed (blank lives in blank_o)
    logic [7:0]         b_attr, sr;
    logic               b_cur;
    logic [7:0]         load_pat, load_attr;
    logic               load_cur;

    logic [4:0]         frame_cnt;
    logic               vs_d;
    logic               unused_row;

    assign cce      = char_ce & pix_ce;
    assign ack_ok   = vram.vram_ack & req_r;
    assign fetch_ok = (state == S_DONE);
    // IDLE only exists straight after reset: nothing was in flight, so it is not a miss
    assign miss     = cce & ~fetch_ok & (state != S_IDLE);

    assign load_pat  = fetch_ok ? pend_pat  : 8'h00;
    assign load_attr = fetch_ok ? pend_attr : 8'h00;
    assign load_cur  = fetch_ok & a_cur;

    assign vram.vram_req  = req_r;
    assign vram.vram_addr = vram_addr_r;
    assign unused_row     = &{1'b0, row_addr};

    function automatic logic [3:0] pix_colour(input logic px, input logic [7:0] attr, input logic cur,
                                              input logic blank, input logic bm, input logic phase);
        logic [3:0] fg, bg, c;
        fg = attr[3:0];
        bg = bm ? {1'b0, attr[6:4]} : attr[7:4];
        c  = px ? fg : bg;
        if (bm & attr[7] & ~phase) c = bg;
        if (cur)                   c = fg;
        if (blank)                 c = 4'h0;
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cce) begin
            // a late ack on the char_ce edge is dropped; the new cell always wins
            state_nxt = display_enable ? S_CHAR : S_DONE;
        end else begin
            case (state)
                S_CHAR:  if (ack_ok) state_nxt = S_ATTR;
                S_ATTR:  if (ack_ok) state_nxt = S_FONT;
                S_FONT:  state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // fetch datapath and stage A/B context
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_r <= 1'b0; req_gap <= 1'b0; vram_addr_r <= '0; font_addr <= '0;
            a_addr <= '0; a_row <= '0; a_de <= 1'b0; a_cur <= 1'b0; a_hs <= 1'b0; a_vs <= 1'b0;
            attr_r <= '0; pend_pat <= '0; pend_attr <= '0;
            b_attr <= '0; b_cur <= 1'b0;
            hsync_o <= 1'b0; vsync_o <= 1'b0; blank_o <= 1'b1; underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (req_gap) begin
                req_r   <= 1'b1;
                req_gap <= 1'b0;
            end
            if (cce) begin
                hsync_o  <= a_hs;
                vsync_o  <= a_vs;
                blank_o  <= ~a_de;
                b_attr   <= load_attr;
                b_cur    <= load_cur;
                underrun <= miss;
                a_addr   <= mem_addr;
                a_row    <= row_addr[ROW_W-1:0];
                a_de     <= display_enable;
                a_cur    <= cursor;
                a_hs     <= hsync_in;
                a_vs     <= vsync_in;
                vram_addr_r <= VRAM_AW'({mem_addr, 1'b0});
                if (display_enable) begin
                    // after a miss the request drops for one clk so the arbiter sees a fresh request
                    req_r   <= ~miss;
                    req_gap <= miss;
                end else begin
                    req_r     <= 1'b0;
                    req_gap   <= 1'b0;
                    pend_pat  <= 8'h00;
                    pend_attr <= 8'h00;
                end
            end else begin
                case (state)
                    S_CHAR: if (ack_ok) begin
                        // font address presented now so the 1-clk ROM is ready when FONT samples it
                        font_addr   <= {vram.vram_data, a_row};
                        vram_addr_r <= VRAM_AW'({a_addr, 1'b1});
                    end
                    S_ATTR: if (ack_ok) begin
                        attr_r <= vram.vram_data;
                        req_r  <= 1'b0;
                    end
                    S_FONT: begin
                        pend_pat  <= font_data;
                        pend_attr <= attr_r;
                    end
                    default: ;
                endcase
            end
        end
    end

    // pixel serialiser
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr    <= '0;
            video <= 4'h0;
        end else if (cce) begin
            sr    <= load_pat;
            video <= pix_colour(load_pat[7], load_attr, load_cur, ~a_de, blink_mode, frame_cnt[BLINK_BIT]);
        end else if (pix_ce) begin
            sr    <= {sr[6:0], 1'b0};
            video <= pix_colour(sr[6], b_attr, b_cur, blank_o, blink_mode, frame_cnt[BLINK_BIT]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            vs_d      <= 1'b0;
        end else begin
            vs_d <= vsync_in;
            if (vsync_in & ~vs_d) frame_cnt <= frame_cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_crtc_text_pixel_gen.sv
module tb_crtc_text_pixel_gen;
`ifdef FONT_8X16_EN
    localparam int FAW = 12;
`else
    localparam int FAW = 11;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n = 1'b0, pix_ce = 1'b0, char_ce = 1'b0;
    logic [13:0]    mem_addr = '0;
    logic [4:0]     row_addr = '0;
    logic           display_enable = 1'b0, cursor = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, blink_mode = 1'b0;
    logic [FAW-1:0] font_addr;
    logic [7:0]     font_data = 8'h00;
    logic [3:0]     video;
    logic           hsync_o, vsync_o, blank_o, underrun;

    crtc_text_pixel_gen_if #(.VRAM_AW(15)) vif ();

    crtc_text_pixel_gen #(.VRAM_AW(15), .BLINK_BIT(4)) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .char_ce(char_ce),
        .mem_addr(mem_addr), .row_addr(row_addr), .display_enable(display_enable),
        .cursor(cursor), .hsync_in(hsync_in), .vsync_in(vsync_in), .blink_mode(blink_mode),
        .vram(vif), .font_addr(font_addr), .font_data(font_data),
        .video(video), .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o), .underrun(underrun)
    );

    logic [7:0]  vram [0:32767];
    logic [7:0]  rom  [0:4095];
    int          n_cmp = 0, n_bad = 0;
    int          ack_dly = 0, req_cycles = 0, fc = 0;
    logic [14:0] addr_q [$];

    typedef struct {
        logic [13:0] addr;
        logic [4:0]  row;
        logic        de, cur, hs, vs, miss;
        logic [7:0]  ch, at, pat;
    } cell_t;
    cell_t prev;

    // synchronous font ROM, one clk from address to data
    always @(posedge clk) font_data <= rom[font_addr];

    // VRAM arbiter: acks ack_dly cycles after each request appears
    initial begin
        int cnt;
        cnt = 0;
        vif.vram_ack  = 1'b0;
        vif.vram_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (vif.vram_req) begin
                req_cycles++;
                if (cnt >= ack_dly) begin
                    vif.vram_ack  = 1'b1;
                    vif.vram_data = vram[vif.vram_addr];
                    addr_q.push_back(vif.vram_addr);
                    cnt = 0;
                end else begin
                    vif.vram_ack = 1'b0;
                    cnt++;
                end
            end else begin
                vif.vram_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int font_idx(input logic [7:0] ch, input logic [4:0] row);
        return (FAW == 12) ? (int'(ch) * 16 + int'(row[3:0])) : (int'(ch) * 8 + int'(row[2:0]));
    endfunction

    // expected k-th pixel of a displayed cell, straight from the colour rules
    function automatic logic [3:0] ref_pix(input cell_t c, input int k, input logic bm, input int fcv);
        logic [3:0] fg, bg;
        logic [7:0] p;
        if (!c.de || c.miss) return 4'h0;
        fg = c.at[3:0];
        bg = bm ? {1'b0, c.at[6:4]} : c.at[7:4];
        if (c.cur) return fg;
        if (bm && c.at[7] && ((fcv % 32) < 16)) return bg;
        p = c.pat;
        return p[7 - k] ? fg : bg;
    endfunction

    function automatic cell_t rand_cell();
        cell_t c;
        c.addr = 14'($urandom);
        c.row  = 5'($urandom_range(0, 31));
        c.de   = ($urandom_range(0, 4) != 0);
        c.cur  = ($urandom_range(0, 9) == 0);
        c.hs   = 1'($urandom);
        c.vs   = 1'($urandom);
        c.miss = 1'b0;
        c.ch = 8'h00; c.at = 8'h00; c.pat = 8'h00;
        return c;
    endfunction

    function automatic cell_t idle_cell();
        cell_t c;
        c = '{addr: 14'h0, row: 5'h0, de: 1'b0, cur: 1'b0, hs: 1'b0, vs: 1'b0, miss: 1'b0,
              ch: 8'h00, at: 8'h00, pat: 8'h00};
        return c;
    endfunction

    // one cell slot: issues c, checks the previously issued cell on the display side
    task automatic do_cell(input cell_t c, input int dly, input bit gaps);
        logic [3:0] exp_pix [8];
        logic       exp_req;
        for (int k = 0; k < 8; k++) exp_pix[k] = ref_pix(prev, k, blink_mode, fc);
        if (c.vs && !vsync_in) fc++;
        ack_dly = dly;
        for (int k = 0; k < 8; k++) begin
            if (gaps && k > 0) begin
                repeat ($urandom_range(0, 1)) begin
                    pix_ce = 1'b0; char_ce = 1'b0;
                    @(posedge clk); #1;
                end
            end
            pix_ce  = 1'b1;
            char_ce = (k == 0);
            if (k == 0) begin
                mem_addr = c.addr; row_addr = c.row; display_enable = c.de;
                cursor = c.cur; hsync_in = c.hs; vsync_in = c.vs;
            end
            @(posedge clk); #1;
            pix_ce = 1'b0; char_ce = 1'b0;
            n_cmp++;
            if (video !== exp_pix[k]) begin
                n_bad++;
                $display("FAIL video k=%0d: got %h expected %h", k, video, exp_pix[k]);
            end
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o} !== {prev.hs, prev.vs, ~prev.de}) begin
                n_bad++;
                $display("FAIL sync_blank k=%0d: got %b expected %b", k, {hsync_o, vsync_o, blank_o},
                         {prev.hs, prev.vs, ~prev.de});
            end
            if (k == 0) begin
                n_cmp++;
                if (underrun !== prev.miss) begin
                    n_bad++;
                    $display("FAIL underrun_pulse: got %b expected %b", underrun, prev.miss);
                end
                exp_req = c.de && !prev.miss;
                n_cmp++;
                if (vif.vram_req !== exp_req) begin
                    n_bad++;
                    $display("FAIL req_start: got %b expected %b", vif.vram_req, exp_req);
                end
                if (exp_req) begin
                    n_cmp++;
                    if (vif.vram_addr !== {c.addr, 1'b0}) begin
                        n_bad++;
                        $display("FAIL char_addr: got %h expected %h", vif.vram_addr, {c.addr, 1'b0});
                    end
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (underrun !== 1'b0) begin
                    n_bad++;
                    $display("FAIL underrun_width: got %b expected 0", underrun);
                end
                if (c.de && prev.miss && !gaps) begin
                    n_cmp++;
                    if (vif.vram_req !== 1'b1) begin
                        n_bad++;
                        $display("FAIL req_reissue: got %b expected 1", vif.vram_req);
                    end
                end
            end
        end
        // snapshot the memory contents the design fetched for this cell
        c.ch  = vram[{c.addr, 1'b0}];
        c.at  = vram[{c.addr, 1'b1}];
        c.pat = rom[font_idx(c.ch, c.row)];
        prev  = c;
    endtask

    task automatic apply_reset();
        pix_ce = 1'b0; char_ce = 1'b0; vsync_in = 1'b0; hsync_in = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        prev = idle_cell();
        fc = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({video, hsync_o, vsync_o, blank_o, vif.vram_req, underrun} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got v=%h hs=%b vs=%b bl=%b req=%b ur=%b expected v=0 hs=0 vs=0 bl=1 req=0 ur=0",
                     video, hsync_o, vsync_o, blank_o, vif.vram_req, underrun);
        end
        release_reset();
    endtask

    task automatic test_basic();
        cell_t c;
        blink_mode = 1'b0;
        c = rand_cell();
        c.de = 1'b1; c.cur = 1'b0; c.vs = 1'b0;
        vram[{c.addr, 1'b0}] = 8'h41;
        vram[{c.addr, 1'b1}] = 8'h1E;
        rom[font_idx(8'h41, c.row)] = 8'h3C;
        addr_q.delete();
        do_cell(c, 1, 1'b0);
        n_cmp++;
        if (addr_q.size() !== 2) begin
            n_bad++;
            $display("FAIL addr_seq_len: got %0d expected 2", addr_q.size());
        end else begin
            n_cmp++;
            if (addr_q[0] !== {c.addr, 1'b0} || addr_q[1] !== {c.addr, 1'b1}) begin
                n_bad++;
                $display("FAIL addr_seq: got %h,%h expected %h,%h", addr_q[0], addr_q[1],
                         {c.addr, 1'b0}, {c.addr, 1'b1});
            end
        end
        c = rand_cell(); c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
    endtask

    task automatic test_underrun();
        cell_t c;
        c = rand_cell(); c.de = 1'b1; c.vs = 1'b0; c.miss = 1'b1;
        do_cell(c, 20, 1'b0);
        c = rand_cell(); c.de = 1'b1; c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
        c = rand_cell(); c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
    endtask

    task automatic vsync_pulses(input int n);
        pix_ce = 1'b0; char_ce = 1'b0;
        vsync_in = 1'b0;
        @(posedge clk); #1;
        repeat (n) begin
            vsync_in = 1'b1; @(posedge clk); #1;
            vsync_in = 1'b0; @(posedge clk); #1;
            fc++;
        end
    endtask

    task automatic test_blink();
        cell_t c, f;
        logic [13:0] a;
        a = 14'($urandom);
        vram[{a, 1'b0}] = 8'h42;
        vram[{a, 1'b1}] = 8'h8F;
        rom[font_idx(8'h42, 5'd1)] = 8'hFF;
        rom[font_idx(8'h42, 5'd2)] = 8'h0F;
        c = '{addr: a, row: 5'd1, de: 1'b1, cur: 1'b0, hs: 1'b0, vs: 1'b0, miss: 1'b0,
              ch: 8'h00, at: 8'h00, pat: 8'h00};
        f = idle_cell();
        blink_mode = 1'b1;
        if ((fc % 32) < 16) vsync_pulses(16 - (fc % 16));
        do_cell(c, 0, 1'b0);
        do_cell(f, 0, 1'b0);
        vsync_pulses(16);
        do_cell(c, 2, 1'b0);
        do_cell(f, 0, 1'b0);
        blink_mode = 1'b0;
        c.row = 5'd2;
        do_cell(c, 1, 1'b0);
        do_cell(f, 0, 1'b0);
    endtask

    task automatic test_border();
        cell_t c;
        c = rand_cell(); c.de = 1'b1; c.hs = 1'b0; c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
        c = rand_cell(); c.de = 1'b0; c.hs = 1'b1; c.vs = 1'b0;
        req_cycles = 0;
        do_cell(c, 1, 1'b0);
        n_cmp++;
        if (req_cycles !== 0) begin
            n_bad++;
            $display("FAIL border_no_req: got %0d request cycles expected 0", req_cycles);
        end
        c = rand_cell(); c.de = 1'b1; c.hs = 1'b0; c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
    endtask

    task automatic test_cursor();
        cell_t c;
        c = rand_cell(); c.de = 1'b1; c.cur = 1'b1; c.vs = 1'b0;
        vram[{c.addr, 1'b0}] = 8'h20;
        vram[{c.addr, 1'b1}] = 8'h07;
        rom[font_idx(8'h20, c.row)] = 8'h00;
        do_cell(c, 0, 1'b0);
        c = rand_cell(); c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
    endtask

    task automatic test_reset_midfetch();
        cell_t c;
        c = rand_cell(); c.de = 1'b1; c.vs = 1'b0;
        ack_dly = 1;
        for (int k = 0; k < 3; k++) begin
            pix_ce = 1'b1; char_ce = (k == 0);
            if (k == 0) begin
                mem_addr = c.addr; row_addr = c.row; display_enable = 1'b1;
                cursor = c.cur; hsync_in = c.hs; vsync_in = 1'b0;
            end
            @(posedge clk); #1;
        end
        pix_ce = 1'b0; char_ce = 1'b0;
        n_cmp++;
        if (vif.vram_req !== 1'b1 || vif.vram_addr !== {c.addr, 1'b1}) begin
            n_bad++;
            $display("FAIL attr_phase: got req=%b addr=%h expected req=1 addr=%h",
                     vif.vram_req, vif.vram_addr, {c.addr, 1'b1});
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({vif.vram_req, video, blank_o} !== {1'b0, 4'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_midfetch: got req=%b v=%h bl=%b expected req=0 v=0 bl=1",
                     vif.vram_req, video, blank_o);
        end
        release_reset();
        c = rand_cell(); c.de = 1'b1; c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
        c = rand_cell(); c.vs = 1'b0;
        do_cell(c, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        cell_t c;
        blink_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            c = rand_cell();
            do_cell(c, $urandom_range(0, 2), 1'($urandom));
        end
        blink_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            c = rand_cell(); c.vs = 1'b0;
            do_cell(c, $urandom_range(0, 2), 1'($urandom));
        end
        blink_mode = 1'b0;
        c = idle_cell();
        do_cell(c, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++)  rom[i]  = 8'($urandom);
        prev = idle_cell();
        test_reset();
        test_basic();
        test_underrun();
        test_border();
        test_cursor();
        test_blink();
        test_reset_midfetch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
